switch_allocator: RTL and testbench
===================================

# switch_allocator

Wormhole switch allocator for the 5-port mesh router. It takes the one-hot output-port requests produced by the per-input routing stage and grants each output port to one input with round-robin fairness. It holds each grant from head flit to tail flit, and drives the per-input ready and per-output valid handshakes of the crossbar.

## Interface
- N_PORTS, 5, number of router ports (inputs = outputs); index 0..4 = N, S, E, W, local
- ALLOW_UTURN, 0, when 0 a request from input i for output i is ignored
- clk  in  1  router clock; all state on rising edge
- arst  in  1  reset, asynchronous, active-low (asserted when 0)
- valid_i  in  N_PORTS  input i holds a flit
- head_i  in  N_PORTS  flit at input i is a head flit
- tail_i  in  N_PORTS  flit at input i is a tail flit (head_i & tail_i = single-flit packet)
- req_i  in  N_PORTS*N_PORTS  req_i[i*N_PORTS+o]: input i requests output o (one-hot per input, from routing stage)
- out_ready_i  in  N_PORTS  output o can accept a flit this cycle
- in_ready_o  out  N_PORTS  flit at input i is transferred this cycle
- out_valid_o  out  N_PORTS  output o receives a flit this cycle
- sel_o  out  N_PORTS*N_PORTS  sel_o[o*N_PORTS+i]: crossbar select, output o driven from input i (registered lock owner)
- locked_o  out  N_PORTS  output o is in LOCKED state

## Operation
- Request masking: each input's request vector is reduced to its lowest set bit; if ALLOW_UTURN=0, bit i of input i is cleared. A request is eligible only when valid_i & head_i.
- There is one independent 2-state FSM per output o, IDLE/LOCKED, with owner register (3 bits) and priority pointer ptr (last granted input).
- IDLE:
  - candidates = eligible inputs requesting o.
  - The winner is the first candidate searching ptr+1, ptr+2, … modulo N_PORTS.
  - If a candidate exists: owner<=winner, next state LOCKED. Otherwise stay IDLE.
  - No transfer happens in IDLE.
- LOCKED:
  - out_valid_o[o] = valid_i[owner] & out_ready_i[o].
  - in_ready_o[owner] = out_ready_i[o].
  - sel_o row o is one-hot on owner.
  - On a transfer with tail_i[owner]=1: next state IDLE, ptr<=owner.
  - Otherwise stay LOCKED, including when valid_i[owner]=0 (bubble inside a packet).
- An input already owned by some output is excluded from candidates of every other output. Ownership is exclusive, so in_ready_o is an OR of at most one term.
- In IDLE, all outputs for that port are 0: in_ready_o contribution, out_valid_o, sel_o row.

## Timing
- Reset values: all FSMs IDLE, owner=0, ptr=N_PORTS-1 (input 0 has first priority), in_ready_o=0, out_valid_o=0, sel_o=0, locked_o=0.
- Arbitration latency is 1 cycle. A head presented in cycle t is granted at edge t; the first transfer can happen in cycle t+1.
- Throughput inside a packet is 1 flit/cycle while valid_i & out_ready_i.
- Tail transfer in cycle t gives IDLE in cycle t+1. A new packet is granted at t+1 and transfers at t+2, so there is exactly one bubble between packets on an output.
- Simultaneous head requests from several inputs for the same output: one grant per arbitration, in round-robin order. Losers hold their request and are not acked.
- A request on an output that is already LOCKED waits, with no ack, until IDLE.
- Reset asserted mid-packet: all locks drop immediately (asynchronously) and outputs go to 0. Packets in flight are discarded by upstream reset.
- All outputs are combinational from registered state plus valid_i/out_ready_i/tail_i. There is no combinational path from req_i to any output.

## Structure
- The shared router package holds:
  - N_PORTS
  - the port index enumeration (N, S, E, W, LOCAL)
  - the alloc_state_t typedef (IDLE, LOCKED)
- Sub-module rr_arbiter (N-bit request, ptr in, one-hot grant and valid out; combinational) is instantiated once per output.

## Test plan
- Reset then single-flit packet (head&tail) input 0 → output 2, out_ready=1: locked_o[2]=1 next cycle; in_ready_o[0]=1 and out_valid_o[2]=1 for one cycle; IDLE after.
- Inputs 0, 1 and 3 all request output 4 with 2-flit packets, held continuously: grant order 0, 1, 3, 0, …; each packet takes 3 cycles (grant plus 2 flits), so output 4 sees flits in 2 of every 3 cycles.
- 4-flit packet input 2 → output 0 with out_ready_i[0] low in cycles 2–3 and valid_i[2] low in cycle 5: lock is held throughout, no ack while stalled, and all 4 flits transfer in order.
- Input 1 requests output 1 with ALLOW_UTURN=0: never granted. Input 1 with req vector 5'b10100: only output 2 is locked.
- Input 3 → output 0 and input 4 → output 1 simultaneously: both locked in the same cycle and both transfer in parallel.
- arst driven low during the 2nd flit of a 3-flit packet: locked_o, in_ready_o and out_valid_o are 0 immediately. After release, a new head from input 0 is granted before input 4 (ptr=4).

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Shared router definitions: port count, port naming and allocator FSM states,
// plus small one-hot helpers used by the switch allocator.
package switch_allocator_pkg;

  localparam int N_PORTS = 5;
  localparam int IDX_W   = 3;

  typedef enum logic [IDX_W-1:0] {
    P_N     = 3'd0,
    P_S     = 3'd1,
    P_E     = 3'd2,
    P_W     = 3'd3,
    P_LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

  typedef logic [N_PORTS-1:0] port_vec_t;
  typedef logic [IDX_W-1:0]   port_idx_t;

  function automatic port_vec_t lowest_bit(port_vec_t v);
    return v & (~v + port_vec_t'(1));
  endfunction

  function automatic port_vec_t idx_to_onehot(port_idx_t idx);
    port_vec_t v;
    v = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (idx == port_idx_t'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic port_idx_t onehot_to_idx(port_vec_t v);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (v[i]) idx = idx | port_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Crossbar handshake bundle between the router datapath and the switch allocator.
interface switch_allocator_if;
  import switch_allocator_pkg::*;

  logic [N_PORTS-1:0]         valid_i;
  logic [N_PORTS-1:0]         head_i;
  logic [N_PORTS-1:0]         tail_i;
  logic [N_PORTS*N_PORTS-1:0] req_i;
  logic [N_PORTS-1:0]         out_ready_i;
  logic [N_PORTS-1:0]         in_ready_o;
  logic [N_PORTS-1:0]         out_valid_o;
  logic [N_PORTS*N_PORTS-1:0] sel_o;
  logic [N_PORTS-1:0]         locked_o;

  modport master (
    output valid_i, head_i, tail_i, req_i, out_ready_i,
    input  in_ready_o, out_valid_o, sel_o, locked_o
  );

  modport slave (
    input  valid_i, head_i, tail_i, req_i, out_ready_i,
    output in_ready_o, out_valid_o, sel_o, locked_o
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr_i (wrapping)
// wins; ptr_i holds the last granted index.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             valid_o
);

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!valid_o && (j == idx) && req_i[j]) begin
          gnt_o[j] = 1'b1;
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one IDLE/LOCKED FSM per output holds an input from
// head to tail flit, with round-robin choice among competing heads.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter bit ALLOW_UTURN = 1'b0
) (
  input  logic              clk,
  input  logic              arst,
  switch_allocator_if.slave bus
);

  port_vec_t req_m [N_PORTS];
  port_vec_t elig;
  port_vec_t owned;
  port_vec_t in_ready;
  port_vec_t out_valid;
  port_vec_t locked;
  logic [N_PORTS-1:0][N_PORTS-1:0] sel_mat;
  logic [N_PORTS-1:0][N_PORTS-1:0] ir_mat;

  // Per-input request cleanup: keep one output, optionally drop the U-turn.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_in
    localparam port_vec_t UTURN_MASK =
      ALLOW_UTURN ? port_vec_t'(0) : (port_vec_t'(1) << gi);
    port_vec_t req_raw;

    assign req_raw   = bus.req_i[gi*N_PORTS +: N_PORTS];
    assign req_m[gi] = lowest_bit(req_raw) & ~UTURN_MASK;
    assign elig[gi]  = bus.valid_i[gi] & bus.head_i[gi] & ~owned[gi];
  end

  // sel_mat doubles as the ownership map: column i set means input i is taken.
  always_comb begin
    owned    = '0;
    in_ready = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        owned[i]    = owned[i] | sel_mat[o][i];
        in_ready[i] = in_ready[i] | ir_mat[o][i];
      end
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_out
    alloc_state_t state_q, state_d;
    port_idx_t    owner_q, owner_d;
    port_idx_t    ptr_q, ptr_d;
    port_vec_t    cand;
    port_vec_t    gnt;
    port_vec_t    owner_oh;
    logic         gnt_v;
    logic         is_locked;
    logic         owner_valid;
    logic         owner_tail;
    logic         xfer;

    always_comb begin
      cand = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        cand[i] = elig[i] & req_m[i][gi];
      end
    end

    rr_arbiter #(
      .N     (N_PORTS),
      .PTR_W (IDX_W)
    ) u_arb (
      .req_i   (cand),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .valid_o (gnt_v)
    );

    assign owner_oh    = idx_to_onehot(owner_q);
    assign is_locked   = (state_q == LOCKED);
    assign owner_valid = |(bus.valid_i & owner_oh);
    assign owner_tail  = |(bus.tail_i & owner_oh);
    assign xfer        = is_locked & owner_valid & bus.out_ready_i[gi];

    assign sel_mat[gi]   = is_locked ? owner_oh : port_vec_t'(0);
    assign ir_mat[gi]    = sel_mat[gi] & {N_PORTS{bus.out_ready_i[gi]}};
    assign out_valid[gi] = xfer;
    assign locked[gi]    = is_locked;

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
        IDLE: begin
          if (gnt_v) begin
            state_d = LOCKED;
            owner_d = onehot_to_idx(gnt);
          end
        end
        LOCKED: begin
          // A bubble (owner not valid) keeps the lock; only the tail releases it.
          if (xfer && owner_tail) begin
            state_d = IDLE;
            ptr_d   = owner_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= port_idx_t'(N_PORTS - 1);
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.locked_o    = locked;
  assign bus.sel_o       = sel_mat;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: per-cycle vector table plus hand-written
// round-robin and asynchronous-reset sequences.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  typedef struct {
    string       name;
    bit          rst;
    logic [4:0]  valid;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [24:0] req;
    logic [4:0]  rdy;
    logic [4:0]  exp_ir;
    logic [4:0]  exp_ov;
    logic [4:0]  exp_lk;
    logic [24:0] exp_sel;
  } vec_t;

  logic clk;
  logic arst;
  int   total;
  int   bad;
  vec_t vecs[$];

  switch_allocator_if bus_if ();

  switch_allocator #(.ALLOW_UTURN(1'b0)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] rq(int i, int o);
    return 25'(1) << (i*5 + o);
  endfunction

  function automatic logic [24:0] sb(int o, int i);
    return 25'(1) << (o*5 + i);
  endfunction

  function automatic vec_t mk(string n, bit r, logic [4:0] v, logic [4:0] h, logic [4:0] t,
                              logic [24:0] q, logic [4:0] rdy, logic [4:0] ir,
                              logic [4:0] ov, logic [4:0] lk, logic [24:0] sel);
    vec_t x;
    x.name = n; x.rst = r; x.valid = v; x.head = h; x.tail = t; x.req = q;
    x.rdy = rdy; x.exp_ir = ir; x.exp_ov = ov; x.exp_lk = lk; x.exp_sel = sel;
    return x;
  endfunction

  task automatic check(input string nm, input logic [24:0] got, input logic [24:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                       input logic [24:0] q, input logic [4:0] rdy);
    bus_if.valid_i     = v;
    bus_if.head_i      = h;
    bus_if.tail_i      = t;
    bus_if.req_i       = q;
    bus_if.out_ready_i = rdy;
  endtask

  task automatic check_outs(input string nm, input logic [4:0] ir, input logic [4:0] ov,
                            input logic [4:0] lk, input logic [24:0] sel);
    check({nm, "/in_ready"},  25'(bus_if.in_ready_o),  25'(ir));
    check({nm, "/out_valid"}, 25'(bus_if.out_valid_o), 25'(ov));
    check({nm, "/locked"},    25'(bus_if.locked_o),    25'(lk));
    check({nm, "/sel"},       bus_if.sel_o,            sel);
    $display("cyc %s: in_ready=%b out_valid=%b locked=%b sel=%h",
             nm, bus_if.in_ready_o, bus_if.out_valid_o, bus_if.locked_o, bus_if.sel_o);
  endtask

  task automatic do_reset(input string nm);
    arst = 1'b0;
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
    #1;
    check_outs({nm, "/reset"}, 5'b0, 5'b0, 5'b0, 25'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    if (x.rst) do_reset(x.name);
    drive(x.valid, x.head, x.tail, x.req, x.rdy);
    #1;
    check_outs(x.name, x.exp_ir, x.exp_ov, x.exp_lk, x.exp_sel);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    arst  = 1'b0;
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b0);

    // Single-flit packet input 0 -> output 2.
    vecs.push_back(mk("t1_head", 1, 5'b00001, 5'b00001, 5'b00001, rq(0,2), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    vecs.push_back(mk("t1_xfer", 0, 5'b00001, 5'b00001, 5'b00001, rq(0,2), 5'b11111, 5'b00001, 5'b00100, 5'b00100, sb(2,0)));
    vecs.push_back(mk("t1_idle", 0, 5'b0, 5'b0, 5'b0, 25'b0, 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    // 4-flit packet input 2 -> output 0 with ready stall and a valid bubble.
    vecs.push_back(mk("t3_c0", 1, 5'b00100, 5'b00100, 5'b0, rq(2,0), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    vecs.push_back(mk("t3_c1", 0, 5'b00100, 5'b00100, 5'b0, rq(2,0), 5'b11111, 5'b00100, 5'b00001, 5'b00001, sb(0,2)));
    vecs.push_back(mk("t3_c2", 0, 5'b00100, 5'b0, 5'b0, rq(2,0), 5'b11110, 5'b0, 5'b0, 5'b00001, sb(0,2)));
    vecs.push_back(mk("t3_c3", 0, 5'b00100, 5'b0, 5'b0, rq(2,0), 5'b11110, 5'b0, 5'b0, 5'b00001, sb(0,2)));
    vecs.push_back(mk("t3_c4", 0, 5'b00100, 5'b0, 5'b0, rq(2,0), 5'b11111, 5'b00100, 5'b00001, 5'b00001, sb(0,2)));
    vecs.push_back(mk("t3_c5", 0, 5'b0, 5'b0, 5'b0, rq(2,0), 5'b11111, 5'b00100, 5'b0, 5'b00001, sb(0,2)));
    vecs.push_back(mk("t3_c6", 0, 5'b00100, 5'b0, 5'b0, rq(2,0), 5'b11111, 5'b00100, 5'b00001, 5'b00001, sb(0,2)));
    vecs.push_back(mk("t3_c7", 0, 5'b00100, 5'b0, 5'b00100, rq(2,0), 5'b11111, 5'b00100, 5'b00001, 5'b00001, sb(0,2)));
    vecs.push_back(mk("t3_c8", 0, 5'b0, 5'b0, 5'b0, 25'b0, 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    // U-turn request is ignored; multi-hot request keeps only its lowest bit.
    vecs.push_back(mk("t4_u0", 1, 5'b00010, 5'b00010, 5'b00010, rq(1,1), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    vecs.push_back(mk("t4_u1", 0, 5'b00010, 5'b00010, 5'b00010, rq(1,1), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    vecs.push_back(mk("t4_u2", 0, 5'b00010, 5'b00010, 5'b00010, rq(1,1), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    vecs.push_back(mk("t4_m0", 0, 5'b00010, 5'b00010, 5'b00010, rq(1,2) | rq(1,4), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    vecs.push_back(mk("t4_m1", 0, 5'b00010, 5'b00010, 5'b00010, rq(1,2) | rq(1,4), 5'b11111, 5'b00010, 5'b00100, 5'b00100, sb(2,1)));
    vecs.push_back(mk("t4_m2", 0, 5'b0, 5'b0, 5'b0, 25'b0, 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    // Parallel locks: input 3 -> output 0 and input 4 -> output 1.
    vecs.push_back(mk("t5_c0", 1, 5'b11000, 5'b11000, 5'b11000, rq(3,0) | rq(4,1), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));
    vecs.push_back(mk("t5_c1", 0, 5'b11000, 5'b11000, 5'b11000, rq(3,0) | rq(4,1), 5'b11111, 5'b11000, 5'b00011, 5'b00011, sb(0,3) | sb(1,4)));
    vecs.push_back(mk("t5_c2", 0, 5'b0, 5'b0, 5'b0, 25'b0, 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0));

    foreach (vecs[k]) apply(vecs[k]);

    // Round robin: inputs 0, 1, 3 send back-to-back 2-flit packets to output 4.
    begin
      int         cnt [5];
      int         order [4];
      logic [4:0] v, h, t, ir, ov, lk;
      logic [24:0] q, sel;
      order = '{0, 1, 3, 0};
      foreach (cnt[i]) cnt[i] = 0;
      do_reset("t2");
      for (int c = 0; c < 12; c++) begin
        v = 5'b01011;
        h = '0; t = '0; q = '0;
        for (int i = 0; i < 5; i++) begin
          if (v[i]) begin
            h[i] = (cnt[i] == 0);
            t[i] = (cnt[i] == 1);
            q    = q | rq(i, 4);
          end
        end
        drive(v, h, t, q, 5'b11111);
        #1;
        if (c % 3 == 0) begin
          ir = '0; ov = '0; lk = '0; sel = '0;
        end else begin
          ir  = 5'(1) << order[c/3];
          ov  = 5'b10000;
          lk  = 5'b10000;
          sel = sb(4, order[c/3]);
        end
        check_outs($sformatf("t2_c%0d", c), ir, ov, lk, sel);
        for (int i = 0; i < 5; i++) begin
          if (bus_if.in_ready_o[i] && v[i]) cnt[i] = (cnt[i] + 1) % 2;
        end
        @(posedge clk);
        #1;
      end
    end

    // Asynchronous reset mid-packet, then priority pointer restarts at input 0.
    begin
      vec_t x;
      do_reset("t6");
      x = mk("t6_a0", 0, 5'b00010, 5'b00010, 5'b00010, rq(1,3), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0); apply(x);
      x = mk("t6_a1", 0, 5'b00010, 5'b00010, 5'b00010, rq(1,3), 5'b11111, 5'b00010, 5'b01000, 5'b01000, sb(3,1)); apply(x);
      x = mk("t6_a2", 0, 5'b0, 5'b0, 5'b0, 25'b0, 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0); apply(x);
      x = mk("t6_b0", 0, 5'b00001, 5'b00001, 5'b0, rq(0,3), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0); apply(x);
      x = mk("t6_b1", 0, 5'b00001, 5'b00001, 5'b0, rq(0,3), 5'b11111, 5'b00001, 5'b01000, 5'b01000, sb(3,0)); apply(x);
      drive(5'b00001, 5'b0, 5'b0, rq(0,3), 5'b11111);
      #1;
      check_outs("t6_b2", 5'b00001, 5'b01000, 5'b01000, sb(3,0));
      #1;
      arst = 1'b0;
      #1;
      check_outs("t6_arst", 5'b0, 5'b0, 5'b0, 25'b0);
      drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
      @(negedge clk);
      arst = 1'b1;
      @(posedge clk);
      #1;
      x = mk("t6_c0", 0, 5'b10001, 5'b10001, 5'b10001, rq(0,3) | rq(4,3), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0); apply(x);
      x = mk("t6_c1", 0, 5'b10001, 5'b10001, 5'b10001, rq(0,3) | rq(4,3), 5'b11111, 5'b00001, 5'b01000, 5'b01000, sb(3,0)); apply(x);
      x = mk("t6_c2", 0, 5'b10000, 5'b10000, 5'b10000, rq(4,3), 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0); apply(x);
      x = mk("t6_c3", 0, 5'b10000, 5'b10000, 5'b10000, rq(4,3), 5'b11111, 5'b10000, 5'b01000, 5'b01000, sb(3,4)); apply(x);
      x = mk("t6_c4", 0, 5'b0, 5'b0, 5'b0, 25'b0, 5'b11111, 5'b0, 5'b0, 5'b0, 25'b0); apply(x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
